// File: rtl/adc_frame_pkg.sv
// -----------------------------------------------------------------------------
// adc_frame_pkg
// Shared types and constants for the ADC frame sender.
//   frame_state_t : sender FSM state encoding (also exported on the debug port)
//   MAX_LEN_DEF   : default payload limit per frame
//   SYNC0_DEF/SYNC1_DEF : default header sync bytes
//   clamp_len()   : LEN = min(len, max_len) as the 16-bit header length field
// Optional feature macro used by the sender: ADC_FRAME_CSUM_EN
// -----------------------------------------------------------------------------
package adc_frame_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_HDR0   = 4'd1,
    ST_HDR1   = 4'd2,
    ST_LENH   = 4'd3,
    ST_LENL   = 4'd4,
    ST_RD     = 4'd5,
    ST_LAT    = 4'd6,
    ST_DATA   = 4'd7,
    ST_DRAIN  = 4'd8,
    ST_CSUM   = 4'd9,
    ST_CLR    = 4'd10,
    ST_WAITLO = 4'd11
  } frame_state_t;

  localparam int unsigned MAX_LEN_DEF = 4096;
  localparam logic [7:0]  SYNC0_DEF   = 8'hA5;
  localparam logic [7:0]  SYNC1_DEF   = 8'h5A;

  // Header length field; max_len is assumed to fit in 16 bits.
  function automatic logic [15:0] clamp_len(input logic [31:0] len,
                                            input int unsigned max_len);
    return (len > 32'(max_len)) ? 16'(max_len) : len[15:0];
  endfunction

endpackage

// File: rtl/adc_frame_sender_if.sv
// -----------------------------------------------------------------------------
// adc_frame_sender_if
// Byte stream from the frame sender to the SPI transmit shifter.
//   tx_data  : byte being offered
//   tx_valid : tx_data is valid
//   tx_ready : shifter accepts the byte
// Handshake: a byte transfers on every clock edge where tx_valid && tx_ready.
// While tx_valid && !tx_ready the source holds tx_data stable, and tx_valid
// is never withdrawn without a transfer.
// Modports: master = sender side, slave = shifter side.
// -----------------------------------------------------------------------------
interface adc_frame_sender_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/adc_frame_sender.sv
// -----------------------------------------------------------------------------
// adc_frame_sender
// Drains one captured frame from the ADC FIFO and sends it to the SPI shifter
// as: SYNC0, SYNC1, LEN[15:8], LEN[7:0], LEN payload bytes, [checksum].
// LEN = min(len, MAX_LEN); any surplus FIFO bytes are read and discarded.
// After the frame, clear pulses once and the FSM waits for send_en to drop.
//
// Ports:
//   clk, rst_n   : clock (also FIFO read clock), async active-low reset
//   send_en      : level, frame complete in FIFO
//   len[31:0]    : FIFO byte count, sampled when leaving IDLE
//   fifo_q[7:0]  : FIFO read data, valid one cycle after rd_req
//   rd_req       : FIFO read strobe (one cycle per byte)
//   clear        : one-cycle capture re-arm pulse
//   busy         : high in every state except IDLE
//   tx           : adc_frame_sender_if.master (tx_data/tx_valid/tx_ready)
//   dbg_state_o  : current FSM state
//
// Config macro: ADC_FRAME_CSUM_EN adds a CSUM state that sends the modulo-256
// sum of the transmitted payload bytes after the payload.
// All outputs are registered.
// -----------------------------------------------------------------------------
module adc_frame_sender
  import adc_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter logic [7:0]  SYNC0   = SYNC0_DEF,
  parameter logic [7:0]  SYNC1   = SYNC1_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  send_en,
  input  logic [31:0]           len,
  input  logic [7:0]            fifo_q,
  output logic                  rd_req,
  output logic                  clear,
  output logic                  busy,
  adc_frame_sender_if.master    tx,
  output frame_state_t          dbg_state_o
);

  frame_state_t state_q;
  logic [31:0]  len_q;       // raw len, needed for the drain surplus
  logic [15:0]  flen_q;      // clamped LEN sent in the header
  logic [31:0]  cnt_q;       // payload bytes left, then drain reads left
  logic [7:0]   tx_data_q;
  logic         tx_valid_q;
  logic         rd_req_q;
  logic         clear_q;
  logic         busy_q;
`ifdef ADC_FRAME_CSUM_EN
  logic [7:0]   csum_q;
`endif

  logic hs;
  assign hs = tx_valid_q && tx.tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      flen_q     <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      clear_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ADC_FRAME_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (send_en) begin
            state_q    <= ST_HDR0;
            busy_q     <= 1'b1;
            len_q      <= len;
            flen_q     <= clamp_len(len, MAX_LEN);
            cnt_q      <= '0;
            tx_data_q  <= SYNC0;
            tx_valid_q <= 1'b1;
`ifdef ADC_FRAME_CSUM_EN
            csum_q     <= '0;
`endif
          end
        end

        ST_HDR0: begin
          if (hs) begin
            state_q   <= ST_HDR1;
            tx_data_q <= SYNC1;
          end
        end

        ST_HDR1: begin
          if (hs) begin
            state_q   <= ST_LENH;
            tx_data_q <= flen_q[15:8];
          end
        end

        ST_LENH: begin
          if (hs) begin
            state_q   <= ST_LENL;
            tx_data_q <= flen_q[7:0];
          end
        end

        ST_LENL: begin
          if (hs) begin
            tx_valid_q <= 1'b0;
            if (flen_q != 16'd0) begin
              state_q  <= ST_RD;
              rd_req_q <= 1'b1;
              cnt_q    <= {16'd0, flen_q};
            end else if (len_q > 32'(MAX_LEN)) begin
              // Only reachable with MAX_LEN = 0: everything is surplus.
              state_q  <= ST_DRAIN;
              rd_req_q <= 1'b1;
              cnt_q    <= len_q - 32'(MAX_LEN);
            end else begin
`ifdef ADC_FRAME_CSUM_EN
              state_q    <= ST_CSUM;
              tx_valid_q <= 1'b1;
              tx_data_q  <= csum_q;
`else
              state_q    <= ST_CLR;
              clear_q    <= 1'b1;
`endif
            end
          end
        end

        ST_RD: begin
          rd_req_q <= 1'b0;
          state_q  <= ST_LAT;
        end

        ST_LAT: begin
          // fifo_q answers the read strobe issued in RD.
          tx_data_q  <= fifo_q;
          tx_valid_q <= 1'b1;
          state_q    <= ST_DATA;
        end

        ST_DATA: begin
          if (hs) begin
            tx_valid_q <= 1'b0;
            cnt_q      <= cnt_q - 32'd1;
`ifdef ADC_FRAME_CSUM_EN
            csum_q     <= csum_q + tx_data_q;
`endif
            if (cnt_q != 32'd1) begin
              state_q  <= ST_RD;
              rd_req_q <= 1'b1;
            end else if (len_q > 32'(MAX_LEN)) begin
              state_q  <= ST_DRAIN;
              rd_req_q <= 1'b1;
              cnt_q    <= len_q - 32'(MAX_LEN);
            end else begin
`ifdef ADC_FRAME_CSUM_EN
              // The accumulator has not absorbed this last byte yet.
              state_q    <= ST_CSUM;
              tx_valid_q <= 1'b1;
              tx_data_q  <= csum_q + tx_data_q;
`else
              state_q    <= ST_CLR;
              clear_q    <= 1'b1;
`endif
            end
          end
        end

        ST_DRAIN: begin
          // rd_req_q doubles as the phase bit: read cycle, then gap cycle,
          // matching the RD/LAT spacing of the payload loop.
          if (rd_req_q) begin
            rd_req_q <= 1'b0;
            cnt_q    <= cnt_q - 32'd1;
          end else if (cnt_q != 32'd0) begin
            rd_req_q <= 1'b1;
          end else begin
`ifdef ADC_FRAME_CSUM_EN
            state_q    <= ST_CSUM;
            tx_valid_q <= 1'b1;
            tx_data_q  <= csum_q;
`else
            state_q    <= ST_CLR;
            clear_q    <= 1'b1;
`endif
          end
        end

        ST_CSUM: begin
          if (hs) begin
            tx_valid_q <= 1'b0;
            clear_q    <= 1'b1;
            state_q    <= ST_CLR;
          end
        end

        ST_CLR: begin
          clear_q <= 1'b0;
          state_q <= ST_WAITLO;
        end

        ST_WAITLO: begin
          // Wait for the capture side to drop its level before re-arming.
          if (!send_en) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          tx_valid_q <= 1'b0;
          rd_req_q   <= 1'b0;
          clear_q    <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign rd_req      = rd_req_q;
  assign clear       = clear_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_adc_frame_sender.sv
// -----------------------------------------------------------------------------
// tb_adc_frame_sender
// Directed frames against a simple FIFO model; expected bytes are queued when
// a frame is launched and popped by an independent monitor on each handshake.
// -----------------------------------------------------------------------------
module tb_adc_frame_sender;
  import adc_frame_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        send_en = 1'b0;
  logic [31:0] len = '0;
  logic [7:0]  fifo_q = 8'h00;
  logic        rd_req, clear, busy;
  frame_state_t dbg_state;
  logic [7:0]  tx_data;
  logic        tx_valid;

  adc_frame_sender_if tx_if();
  assign tx_data  = tx_if.tx_data;
  assign tx_valid = tx_if.tx_valid;

  adc_frame_sender dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .send_en     (send_en),
    .len         (len),
    .fifo_q      (fifo_q),
    .rd_req      (rd_req),
    .clear       (clear),
    .busy        (busy),
    .tx          (tx_if),
    .dbg_state_o (dbg_state)
  );

  // FIFO model: normal mode, data one cycle after the strobe; rd_ptr also
  // serves as the running count of read strobes.
  logic [7:0] mem [0:16383];
  int rd_ptr = 0;
  always @(posedge clk) begin
    if (rd_req) begin
      fifo_q <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // scoreboard
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  int clr_cnt = 0;
  logic holding = 1'b0;
  logic [7:0] hold_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: samples 1 time unit after the falling edge, i.e. the values the
  // next rising edge will see
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (clear) clr_cnt++;
      if (!rst_n) begin
        holding = 1'b0;
      end else begin
        if (holding) begin
          chk("hold_valid", 32'(tx_valid), 32'd1);
          chk("hold_data", 32'(tx_data), 32'(hold_data));
        end
        if (tx_valid && tx_if.tx_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got %0h expected none", tx_data);
          end else begin
            chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
          end
          holding = 1'b0;
        end else if (tx_valid) begin
          holding = 1'b1;
          hold_data = tx_data;
        end else begin
          holding = 1'b0;
        end
      end
    end
  end

  // driver tasks
  task automatic queue_frame(input int n);
    int plen;
    logic [15:0] pl16;
    logic [7:0] sum;
    plen = (n > 4096) ? 4096 : n;
    pl16 = 16'(plen);
    sum = 8'h00;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(pl16[15:8]);
    exp_q.push_back(pl16[7:0]);
    for (int i = 0; i < plen; i++) begin
      exp_q.push_back(mem[rd_ptr + i]);
      sum = sum + mem[rd_ptr + i];
    end
`ifdef ADC_FRAME_CSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  task automatic run_frame(input int n, input bit stall, input bit hold_high);
    int base;
    int c0;
    bit got;
    base = rd_ptr;
    c0 = clr_cnt;
    queue_frame(n);
    @(negedge clk);
    len = n;
    send_en = 1'b1;
    @(negedge clk);
    #2;
    chk("first_valid", 32'(tx_valid), 32'd1);
    chk("first_sync0", 32'(tx_data), 32'hA5);
    if (stall) begin
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
        @(negedge clk);
        if (dbg_state == ST_DATA) got = 1'b1;
      end
      chk("stall_reach_data", 32'(got), 32'd1);
      tx_if.tx_ready = 1'b0;
      repeat (5) @(negedge clk);
      tx_if.tx_ready = 1'b1;
    end
    got = 1'b0;
    for (int k = 0; k < 20000 && !got; k++) begin
      @(negedge clk);
      #2;
      if (clr_cnt != c0) got = 1'b1;
    end
    chk("clear_seen", 32'(got), 32'd1);
    repeat (3) @(negedge clk);
    #2;
    chk("clear_once", 32'(clr_cnt - c0), 32'd1);
    chk("rd_count", 32'(rd_ptr - base), 32'(n));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    if (hold_high) begin
      repeat (10) @(negedge clk);
      #2;
      chk("waitlo_state", 32'(dbg_state), 32'(ST_WAITLO));
      chk("waitlo_busy", 32'(busy), 32'd1);
      chk("waitlo_no_tx", 32'(tx_valid), 32'd0);
      chk("waitlo_no_rd", 32'(rd_ptr - base), 32'(n));
    end
    @(negedge clk);
    send_en = 1'b0;
    @(negedge clk);
    #2;
    chk("idle_after", 32'(dbg_state), 32'(ST_IDLE));
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rd_req"}, 32'(rd_req), 32'd0);
    chk({tag, "_clear"}, 32'(clear), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // watchdog
  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int base;
    int c0;
    bit got;
    tx_if.tx_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // len=4, payload 01..04 (checksum 0A)
    base = rd_ptr;
    mem[base + 0] = 8'h01;
    mem[base + 1] = 8'h02;
    mem[base + 2] = 8'h03;
    mem[base + 3] = 8'h04;
    run_frame(4, 1'b0, 1'b0);

    // len=0: header only, no reads
    run_frame(0, 1'b0, 1'b0);

    // len=4100: clamped to 4096, 4 surplus bytes drained
    base = rd_ptr;
    for (int i = 0; i < 4100; i++) mem[base + i] = 8'((i * 13 + 7) & 255);
    run_frame(4100, 1'b0, 1'b0);

    // back-pressure on a payload byte
    base = rd_ptr;
    mem[base + 0] = 8'h10;
    mem[base + 1] = 8'h20;
    mem[base + 2] = 8'h30;
    run_frame(3, 1'b1, 1'b0);

    // send_en held high after clear
    base = rd_ptr;
    mem[base + 0] = 8'hFF;
    mem[base + 1] = 8'h02;
    run_frame(2, 1'b0, 1'b1);

    // reset in the middle of the payload
    base = rd_ptr;
    for (int i = 0; i < 8; i++) mem[base + i] = 8'(8'h40 + i);
    queue_frame(8);
    c0 = clr_cnt;
    @(negedge clk);
    len = 8;
    send_en = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (dbg_state == ST_DATA && rd_ptr - base >= 2) got = 1'b1;
    end
    chk("reset_reach_payload", 32'(got), 32'd1);
    rst_n = 1'b0;
    send_en = 1'b0;
    #2;
    check_outputs_zero("midreset");
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2;
    chk("midreset_no_clear", 32'(clr_cnt - c0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = rd_ptr;
    mem[base + 0] = 8'h77;
    mem[base + 1] = 8'h88;
    run_frame(2, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
